// File: rtl/xor_pkg.sv
// Shared types and helpers for the XOR accumulation datapath.
package xor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Wide enough for any word this datapath carries; zero-extension leaves the XOR unchanged.
  localparam int XOR_FN_W = 256;

  function automatic logic xor_reduce(input logic [XOR_FN_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/xor_reduce_tree.sv
// Balanced combinational XOR tree: folds a WIDTH-bit word to one parity bit.
// Zero latency; no handshake.
module xor_reduce_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word,
  output logic             parity
);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign parity = word[0];
    end else begin : g_split
      localparam int LO = WIDTH / 2;
      logic p_lo;
      logic p_hi;

      xor_reduce_tree #(.WIDTH(LO)) u_lo (
        .word   (word[LO-1:0]),
        .parity (p_lo)
      );

      xor_reduce_tree #(.WIDTH(WIDTH - LO)) u_hi (
        .word   (word[WIDTH-1:LO]),
        .parity (p_hi)
      );

      assign parity = p_lo ^ p_hi;
    end
  endgenerate

endmodule

// File: rtl/xor_accumulator.sv
// Frame XOR/parity/beat-count engine; result registered one cycle after the closing beat,
// in_ready drops only while a result is held and out_ready is low. Optional check: XOR_ACC_CHECK_EN.
module xor_accumulator
  import xor_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  parameter  int ODD       = 0,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_parity,
  output logic [CW-1:0]    out_beats,
  output logic             out_ovf
`ifdef XOR_ACC_CHECK_EN
  ,
  input  logic             exp_parity,
  output logic             out_err
`endif
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);
  localparam logic          PAR_INV = (ODD == PAR_ODD);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             accept;
  logic             close;
  logic             par_nxt;

  assign in_ready = (state != HOLD) || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    close     = 1'b0;
    if (accept) begin
      // Only an open frame folds; from IDLE or a retiring HOLD the beat starts fresh.
      if (state == ACCUM) begin
        acc_nxt = acc ^ in_data;
        cnt_nxt = cnt + CW'(1);
      end else begin
        acc_nxt = in_data;
        cnt_nxt = CW'(1);
      end
      close     = in_last || (cnt_nxt == MAX_CNT);
      state_nxt = close ? HOLD : ACCUM;
    end else if ((state == HOLD) && out_ready) begin
      state_nxt = IDLE;
    end
  end

  xor_reduce_tree #(.WIDTH(WIDTH)) u_tree (
    .word   (acc_nxt),
    .parity (par_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_parity <= PAR_INV;
      out_beats  <= '0;
      out_ovf    <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      out_valid <= (state_nxt == HOLD);
      if (close) begin
        out_word   <= acc_nxt;
        out_parity <= par_nxt ^ PAR_INV;
        out_beats  <= cnt_nxt;
        out_ovf    <= !in_last;
      end
    end
  end

`ifdef XOR_ACC_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err <= 1'b0;
    end else if (close) begin
      out_err <= ((par_nxt ^ PAR_INV) != exp_parity) || !in_last;
    end
  end
`endif

endmodule

// File: tb/tb_xor_accumulator.sv
// Bench for xor_accumulator: vector table plus scoreboard on unit A, hand sequences for reset and ODD parity.
module tb_xor_accumulator;

  localparam int W    = 8;
  localparam int CWA  = $clog2(4 + 1);
  localparam int CWB  = $clog2(16 + 1);
  localparam int NVEC = 29;

  typedef struct {
    logic           vld;
    logic [W-1:0]   dat;
    logic           lst;
    logic           ordy;
    logic           rdy;
    logic           oval;
    logic           cl;
    logic [W-1:0]   w;
    logic           p;
    logic [CWA-1:0] b;
    logic           ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0]   w;
    logic           p;
    logic [CWA-1:0] b;
    logic           ovf;
    logic           err;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic           a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
  logic [W-1:0]   a_in_data, a_out_word;
  logic           a_out_parity, a_out_ovf;
  logic [CWA-1:0] a_out_beats;

  logic           b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
  logic [W-1:0]   b_in_data, b_out_word;
  logic           b_out_parity, b_out_ovf;
  logic [CWB-1:0] b_out_beats;

`ifdef XOR_ACC_CHECK_EN
  logic a_exp_parity, a_out_err, b_exp_parity, b_out_err;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[NVEC];
  res_t sb[$];

  always #5 clk = ~clk;

  xor_accumulator #(.WIDTH(W), .MAX_BEATS(4), .ODD(0)) u_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_data    (a_in_data),
    .in_last    (a_in_last),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_word   (a_out_word),
    .out_parity (a_out_parity),
    .out_beats  (a_out_beats),
    .out_ovf    (a_out_ovf)
`ifdef XOR_ACC_CHECK_EN
    ,
    .exp_parity (a_exp_parity),
    .out_err    (a_out_err)
`endif
  );

  xor_accumulator #(.WIDTH(W), .MAX_BEATS(16), .ODD(1)) u_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_data    (b_in_data),
    .in_last    (b_in_last),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_word   (b_out_word),
    .out_parity (b_out_parity),
    .out_beats  (b_out_beats),
    .out_ovf    (b_out_ovf)
`ifdef XOR_ACC_CHECK_EN
    ,
    .exp_parity (b_exp_parity),
    .out_err    (b_out_err)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [W-1:0] dat, input logic lst,
                              input logic ordy, input logic rdy, input logic oval,
                              input logic cl, input logic [W-1:0] w, input logic p,
                              input logic [CWA-1:0] b, input logic ovf);
    vec_t v;
    v.vld = vld; v.dat = dat; v.lst = lst; v.ordy = ordy; v.rdy = rdy; v.oval = oval;
    v.cl = cl; v.w = w; v.p = p; v.b = b; v.ovf = ovf;
    return v;
  endfunction

  task automatic push_exp(input logic [W-1:0] w, input logic p, input logic [CWA-1:0] b,
                          input logic ovf, input logic ep);
    res_t r;
    r.w = w; r.p = p; r.b = b; r.ovf = ovf;
    r.err = (p != ep) || ovf;
    sb.push_back(r);
  endtask

  // Result retires on the cycle it is valid with out_ready high.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got unexpected result %0h, expected none", a_out_word);
      end else begin
        res_t r;
        r = sb.pop_front();
        chk("sb out_word", 32'(a_out_word), 32'(r.w));
        chk("sb out_parity", 32'(a_out_parity), 32'(r.p));
        chk("sb out_beats", 32'(a_out_beats), 32'(r.b));
        chk("sb out_ovf", 32'(a_out_ovf), 32'(r.ovf));
`ifdef XOR_ACC_CHECK_EN
        chk("sb out_err", 32'(a_out_err), 32'(r.err));
`endif
      end
    end
  end

  initial begin
    //            vld dat    lst ordy rdy oval cl  w      p  b  ovf
    vecs[0]  = mk(1, 8'hA5, 1, 1, 1, 0, 1, 8'hA5, 0, 1, 0);
    vecs[1]  = mk(0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0);
    vecs[2]  = mk(1, 8'h01, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    vecs[3]  = mk(1, 8'h01, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    vecs[4]  = mk(1, 8'h01, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    vecs[5]  = mk(1, 8'h01, 0, 1, 1, 0, 1, 8'h00, 0, 4, 1);
    vecs[6]  = mk(1, 8'h01, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0);
    vecs[7]  = mk(1, 8'h80, 1, 1, 1, 0, 1, 8'h81, 0, 2, 0);
    vecs[8]  = mk(1, 8'h13, 1, 1, 1, 1, 1, 8'h13, 1, 1, 0);
    vecs[9]  = mk(1, 8'h22, 1, 1, 1, 1, 1, 8'h22, 0, 1, 0);
    vecs[10] = mk(0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0);
    vecs[11] = mk(1, 8'h0F, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    vecs[12] = mk(1, 8'hF0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    vecs[13] = mk(1, 8'hFF, 1, 0, 1, 0, 1, 8'h00, 0, 3, 0);
    for (int i = 14; i < 19; i++)
      vecs[i] = mk(1, 8'h5A, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    vecs[19] = mk(0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0);
    vecs[20] = mk(1, 8'h33, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    vecs[21] = mk(0, 8'hFF, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    vecs[22] = mk(1, 8'h45, 1, 1, 1, 0, 1, 8'h76, 1, 2, 0);
    vecs[23] = mk(1, 8'h10, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0);
    vecs[24] = mk(1, 8'h20, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    vecs[25] = mk(1, 8'h40, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    vecs[26] = mk(1, 8'h80, 1, 1, 1, 0, 1, 8'hF0, 0, 4, 0);
    vecs[27] = mk(0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0);
    vecs[28] = mk(0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);

    a_in_valid = 0; a_in_data = '0; a_in_last = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_in_last = 0; b_out_ready = 0;
`ifdef XOR_ACC_CHECK_EN
    a_exp_parity = 0; b_exp_parity = 1;
`endif

    // Reset values
    #1 rst = 1;
    #2;
    chk("rst a in_ready", 32'(a_in_ready), 32'd1);
    chk("rst a out_valid", 32'(a_out_valid), 32'd0);
    chk("rst a out_word", 32'(a_out_word), 32'd0);
    chk("rst a out_parity", 32'(a_out_parity), 32'd0);
    chk("rst a out_beats", 32'(a_out_beats), 32'd0);
    chk("rst a out_ovf", 32'(a_out_ovf), 32'd0);
    chk("rst b out_parity", 32'(b_out_parity), 32'd1);
`ifdef XOR_ACC_CHECK_EN
    chk("rst a out_err", 32'(a_out_err), 32'd0);
`endif
    @(negedge clk) rst = 0;

    // Odd-parity unit: 0F ^ F0 ^ FF = 00, parity inverted to 1, held while out_ready low
    @(posedge clk); #1 b_in_valid = 1; b_in_data = 8'h0F; b_in_last = 0;
    @(posedge clk); #1 b_in_data = 8'hF0;
    @(posedge clk); #1 b_in_data = 8'hFF; b_in_last = 1;
    @(posedge clk); #1 b_in_valid = 0; b_in_last = 0;
    @(negedge clk);
    chk("odd out_valid", 32'(b_out_valid), 32'd1);
    chk("odd out_word", 32'(b_out_word), 32'h00);
    chk("odd out_parity", 32'(b_out_parity), 32'd1);
    chk("odd out_beats", 32'(b_out_beats), 32'd3);
    chk("odd out_ovf", 32'(b_out_ovf), 32'd0);
    chk("odd in_ready held", 32'(b_in_ready), 32'd0);
`ifdef XOR_ACC_CHECK_EN
    chk("odd out_err", 32'(b_out_err), 32'd0);
`endif
    b_out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("odd retire out_valid", 32'(b_out_valid), 32'd0);

    // Table-driven traffic on unit A
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      a_in_valid = vecs[i].vld; a_in_data = vecs[i].dat;
      a_in_last = vecs[i].lst; a_out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i), 32'(a_in_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d out_valid", i), 32'(a_out_valid), 32'(vecs[i].oval));
      if (vecs[i].cl)
        push_exp(vecs[i].w, vecs[i].p, vecs[i].b, vecs[i].ovf, 1'b0);
    end

    // Reset mid-frame after two beats: outputs clear without a clock edge
    @(posedge clk); #1 a_in_valid = 1; a_in_data = 8'h55; a_in_last = 0; a_out_ready = 1;
    @(posedge clk); #1 a_in_data = 8'hAA;
    @(posedge clk); #1 a_in_valid = 0;
    #2 rst = 1;
    #1;
    chk("midrst in_ready", 32'(a_in_ready), 32'd1);
    chk("midrst out_valid", 32'(a_out_valid), 32'd0);
    chk("midrst out_word", 32'(a_out_word), 32'd0);
    chk("midrst out_parity", 32'(a_out_parity), 32'd0);
    chk("midrst out_beats", 32'(a_out_beats), 32'd0);
    chk("midrst out_ovf", 32'(a_out_ovf), 32'd0);
    sb.delete();
    @(negedge clk) rst = 0;
    @(posedge clk); #1 a_in_valid = 1; a_in_data = 8'h3C; a_in_last = 1;
`ifdef XOR_ACC_CHECK_EN
    a_exp_parity = 1;
`endif
    @(negedge clk);
    chk("post-rst in_ready", 32'(a_in_ready), 32'd1);
`ifdef XOR_ACC_CHECK_EN
    push_exp(8'h3C, 1'b0, 3'd1, 1'b0, 1'b1);
`else
    push_exp(8'h3C, 1'b0, 3'd1, 1'b0, 1'b0);
`endif
    @(posedge clk); #1 a_in_valid = 0; a_in_last = 0;
`ifdef XOR_ACC_CHECK_EN
    a_exp_parity = 0;
`endif
    @(posedge clk); #1;

    // Reset while a result is held
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h7E; a_in_last = 1;
    @(posedge clk); #1 a_in_valid = 0; a_in_last = 0;
    @(negedge clk);
    chk("hold out_valid", 32'(a_out_valid), 32'd1);
    chk("hold out_word", 32'(a_out_word), 32'h7E);
    #2 rst = 1;
    #1;
    chk("holdrst out_valid", 32'(a_out_valid), 32'd0);
    chk("holdrst out_word", 32'(a_out_word), 32'd0);
    chk("holdrst in_ready", 32'(a_in_ready), 32'd1);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle after rst out_valid", 32'(a_out_valid), 32'd0);

    chk("sb drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
